// File: rtl/uart_rx_deser.sv
// uart_rx_deser: receive-side UART deserializer.
//   Oversamples the asynchronous serial line, recovers 8N1 frames (8E1 when
//   UART_RX_PARITY_EN is defined), validates start/stop (and parity) bits and
//   buffers good bytes in a small FIFO with a valid/ready pop interface.
// Parameters:
//   CLK_FREQ   - system clock frequency in Hz
//   BAUD       - line rate in bit/s
//   FIFO_DEPTH - receive FIFO entries (power of 2, >= 2)
// Ports:
//   clk_i        - system clock
//   rst_i        - asynchronous active-high reset
//   rx_i         - serial line, asynchronous, idle high
//   rdata_o      - byte at FIFO head, 0 when empty
//   rvalid_o     - FIFO non-empty
//   rready_i     - pops head byte when rvalid_o is high
//   frame_err_o  - one-cycle pulse: stop bit sampled low
//   overflow_o   - one-cycle pulse: good byte dropped, FIFO full
//   parity_err_o - one-cycle pulse: parity mismatch (0 without UART_RX_PARITY_EN)
// Configuration macro: UART_RX_PARITY_EN (defined -> 8E1 with parity check).
module uart_rx_deser #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] rdata_o,
  output logic       rvalid_o,
  input  logic       rready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic       parity_err_o
);

  localparam int BitCycles = CLK_FREQ / BAUD;
  localparam int HalfBit   = BitCycles / 2;
  localparam int CntW      = $clog2(BitCycles);
  localparam int PtrW      = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] BitLoad   = CntW'(BitCycles - 1);
  localparam logic [CntW-1:0] HalfLoad  = CntW'(HalfBit - 1);
  localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic            meta_r, sync_r, rx_s;
  state_t          state_r, state_next_s;
  logic [CntW-1:0] cnt_r, cnt_next_s;
  logic [7:0]      shift_r, shift_next_s;
  logic [2:0]      bit_idx_r, bit_next_s;
  logic            brk_r, brk_next_s;
  logic            push_s, frame_err_s, parity_err_s;
`ifdef UART_RX_PARITY_EN
  logic            par_bit_r, par_next_s;
`endif

  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_next_s, wr_ptr_next_s;
  logic [PtrW:0]   count_r, count_next_s;
  logic            pop_s, store_s, overflow_s;
  logic [7:0]      head_next_s;
  logic [7:0]      rdata_r;
  logic            rvalid_r, frame_err_r, overflow_r, parity_err_r;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= rx_i;
      sync_r <= meta_r;
    end
  end
  assign rx_s = sync_r;

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CntW{1'b0}};
      shift_r   <= 8'h00;
      bit_idx_r <= 3'd0;
      brk_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      shift_r   <= shift_next_s;
      bit_idx_r <= bit_next_s;
      brk_r     <= brk_next_s;
`ifdef UART_RX_PARITY_EN
      par_bit_r <= par_next_s;
`endif
    end
  end

  // Frame FSM next-state logic; the counter counts down to 0 at each sample point.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    shift_next_s = shift_r;
    bit_next_s   = bit_idx_r;
    brk_next_s   = brk_r;
    push_s       = 1'b0;
    frame_err_s  = 1'b0;
    parity_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_next_s   = par_bit_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_next_s   = HalfLoad;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == {CntW{1'b0}}) begin
          if (rx_s) begin
            state_next_s = ST_IDLE;          // line back high: glitch
          end else begin
            state_next_s = ST_DATA;
            cnt_next_s   = BitLoad;
            bit_next_s   = 3'd0;
          end
        end else begin
          cnt_next_s = cnt_r - CntW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_r == {CntW{1'b0}}) begin
          shift_next_s = {rx_s, shift_r[7:1]};   // LSB first
          cnt_next_s   = BitLoad;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next_s = ST_PARITY;
`else
            state_next_s = ST_STOP;
`endif
          end else begin
            bit_next_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_next_s = cnt_r - CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_r == {CntW{1'b0}}) begin
          par_next_s   = rx_s;
          cnt_next_s   = BitLoad;
          state_next_s = ST_STOP;
        end else begin
          cnt_next_s = cnt_r - CntW'(1);
        end
      end
`endif
      ST_STOP: begin
        if (brk_r) begin
          // After a framing error, hold here until the line returns high so
          // a long break produces only one error.
          if (rx_s) begin
            brk_next_s   = 1'b0;
            state_next_s = ST_IDLE;
          end else begin
            brk_next_s = 1'b1;
          end
        end else if (cnt_r == {CntW{1'b0}}) begin
          if (!rx_s) begin
            frame_err_s = 1'b1;
            brk_next_s  = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bit_r != even_parity(shift_r)) begin
            parity_err_s = 1'b1;
            state_next_s = ST_IDLE;
`endif
          end else begin
            push_s       = 1'b1;
            state_next_s = ST_IDLE;          // resync at mid-stop
          end
        end else begin
          cnt_next_s = cnt_r - CntW'(1);
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FIFO control: a full FIFO still accepts a push when the head is popped.
  always_comb begin
    pop_s         = rready_i && (count_r != {(PtrW + 1){1'b0}});
    store_s       = push_s && ((count_r != FullCount) || pop_s);
    overflow_s    = push_s && !store_s;
    rd_ptr_next_s = pop_s   ? rd_ptr_r + PtrW'(1) : rd_ptr_r;
    wr_ptr_next_s = store_s ? wr_ptr_r + PtrW'(1) : wr_ptr_r;
    case ({store_s, pop_s})
      2'b10:   count_next_s = count_r + (PtrW + 1)'(1);
      2'b01:   count_next_s = count_r - (PtrW + 1)'(1);
      default: count_next_s = count_r;
    endcase
    // The new head is the byte being written when it lands in the head slot.
    if (count_next_s == {(PtrW + 1){1'b0}}) begin
      head_next_s = 8'h00;
    end else if (store_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = shift_r;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // FIFO storage, pointers and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      rd_ptr_r     <= {PtrW{1'b0}};
      wr_ptr_r     <= {PtrW{1'b0}};
      count_r      <= {(PtrW + 1){1'b0}};
      rdata_r      <= 8'h00;
      rvalid_r     <= 1'b0;
      frame_err_r  <= 1'b0;
      overflow_r   <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      if (store_s) begin
        mem_r[wr_ptr_r] <= shift_r;
      end
      rd_ptr_r     <= rd_ptr_next_s;
      wr_ptr_r     <= wr_ptr_next_s;
      count_r      <= count_next_s;
      rdata_r      <= head_next_s;
      rvalid_r     <= (count_next_s != {(PtrW + 1){1'b0}});
      frame_err_r  <= frame_err_s;
      overflow_r   <= overflow_s;
      parity_err_r <= parity_err_s;
    end
  end

  assign rdata_o     = rdata_r;
  assign rvalid_o    = rvalid_r;
  assign frame_err_o = frame_err_r;
  assign overflow_o  = overflow_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_r;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: a frame driver with a behavioural
// outcome model feeds an expected-byte queue and pulse counters; a negedge
// monitor pops and compares on every rvalid/rready handshake.
module tb_uart_rx_deser;
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115_200;
  localparam int DEPTH    = 4;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int HALF     = BIT / 2;
`ifdef UART_RX_PARITY_EN
  localparam int POST_BITS = 10;
`else
  localparam int POST_BITS = 9;
`endif

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       rready_i = 1'b0;
  logic [7:0] rdata_o;
  logic       rvalid_o, frame_err_o, overflow_o, parity_err_o;

  uart_rx_deser #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .frame_err_o(frame_err_o),
    .overflow_o(overflow_o), .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_ovf = 0, exp_perr = 0;
  int ferr_cnt = 0, ovf_cnt = 0, perr_cnt = 0;
  int empty_bad = 0;
  int rise_cyc = -1;
  int last_t0 = 0;
  logic prev_v = 1'b0, prev_f = 1'b0, prev_o = 1'b0, prev_p = 1'b0;
  logic rand_rdy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Monitor: scoreboard pops on handshakes, pulse counting and width checks.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (rvalid_o && rready_i) begin
        check("byte_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("rx_byte", int'(rdata_o), int'(exp_q.pop_front()));
      end
      if (!rvalid_o && rdata_o != 8'h00) empty_bad <= empty_bad + 1;
      if (rvalid_o && !prev_v) rise_cyc <= cyc;
      if (frame_err_o) begin
        ferr_cnt <= ferr_cnt + 1;
        check("frame_err_width", int'(prev_f), 0);
      end
      if (overflow_o) begin
        ovf_cnt <= ovf_cnt + 1;
        check("overflow_width", int'(prev_o), 0);
      end
      if (parity_err_o) begin
        perr_cnt <= perr_cnt + 1;
        check("parity_err_width", int'(prev_p), 0);
      end
    end
    prev_v <= rvalid_o;
    prev_f <= frame_err_o;
    prev_o <= overflow_o;
    prev_p <= parity_err_o;
  end

  // Hold the line at v for n cycles; optionally randomise rready each cycle.
  task automatic drive_bit(input logic v, input int n);
    rx_i = v;
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_rdy) rready_i = 1'($urandom_range(0, 1));
    end
  endtask

  // Send one frame and predict its outcome from the frame rules.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len,
                            input logic par_flip, input int idle_len);
    logic par;
    logic bad_par;
    par = logic'($countones(b) % 2) ^ par_flip;
`ifdef UART_RX_PARITY_EN
    bad_par = par_flip;
`else
    bad_par = 1'b0;
`endif
    if (!stop_bit) exp_ferr++;
    else if (bad_par) exp_perr++;
    else if (exp_q.size() >= DEPTH) exp_ovf++;
    else exp_q.push_back(b);
    last_t0 = cyc + 2;  // two synchronizer cycles before the FSM sees the start bit
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, BIT);
`endif
    drive_bit(stop_bit, stop_len);
    if (idle_len > 0) drive_bit(1'b1, idle_len);
  endtask

  task automatic drain(input string name);
    rready_i = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    rready_i = 1'b0;
    @(negedge clk);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_rvalid_low"}, int'(rvalid_o), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int bad;
    logic [7:0] rb;
    // Reset values.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("outputs_in_reset", int'({rdata_o, rvalid_o, frame_err_o, overflow_o, parity_err_o}), 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if ({rdata_o, rvalid_o, frame_err_o, overflow_o, parity_err_o} != 12'h000) bad++;
    end
    check("outputs_quiet_after_reset", bad, 0);
    @(posedge clk); #1;

    // Single byte with latency measurement.
    send_frame(8'hA5, 1'b1, BIT, 1'b0, BIT);
    check("single_latency", rise_cyc - last_t0, HALF + POST_BITS * BIT + 1);
    @(negedge clk);
    check("single_rdata", int'(rdata_o), 8'hA5);
    check("single_rvalid", int'(rvalid_o), 1);
    @(posedge clk); #1;

    // Glitch rejection, then framing error with a long break.
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 400);
    check("glitch_no_frame_err", ferr_cnt, exp_ferr);
    send_frame(8'h3C, 1'b0, 2000, 1'b0, 500);
    check("break_frame_err_count", ferr_cnt, exp_ferr);
    drain("after_break");

    // Overflow: five back-to-back bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, BIT, 1'b0, 0);
    drive_bit(1'b1, BIT);
    check("overflow_count", ovf_cnt, exp_ovf);
    check("overflow_fifo_full_rvalid", int'(rvalid_o), 1);
    drain("after_overflow");

    // Reset during data bit 4 of 0xFF, then a clean 0x5A.
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT);
    drive_bit(1'b1, 200);
    rst_i = 1'b1;
    drive_bit(1'b1, 5);
    @(negedge clk);
    check("midframe_reset_outputs", int'({rdata_o, rvalid_o, frame_err_o, overflow_o, parity_err_o}), 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    drive_bit(1'b1, 50);
    send_frame(8'h5A, 1'b1, BIT, 1'b0, BIT);
    drain("after_midframe_reset");

    // Random back-to-back bytes with random rready.
    rand_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, BIT, 1'b0, 0);
    end
    drive_bit(1'b1, BIT);
    rand_rdy = 1'b0;
    drain("after_random");

`ifdef UART_RX_PARITY_EN
    // Parity: correct bit accepted, flipped bit rejected.
    send_frame(8'h07, 1'b1, BIT, 1'b0, BIT);
    send_frame(8'h07, 1'b1, BIT, 1'b1, BIT);
    check("parity_err_count", perr_cnt, exp_perr);
    drain("after_parity");
`endif

    check("frame_err_total", ferr_cnt, exp_ferr);
    check("overflow_total", ovf_cnt, exp_ovf);
    check("parity_err_total", perr_cnt, exp_perr);
    check("rdata_zero_when_empty", empty_bad, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
